// File: rtl/button_tx_arbiter.sv
// button_tx_arbiter: shares one UART transmitter between NUM_BTNS push-button
// channels. Single-cycle press pulses latch pending requests. A round-robin
// arbiter grants one request at a time and sends BYTE_BASE+index through a
// one-cycle start strobe, sequenced on the transmitter's busy flag.
//
// Optional build macro BTN_TX_CRLF_EN: each button byte is followed by
// CR (0x0D) and LF (0x0A) before the arbiter returns to IDLE.
module button_tx_arbiter #(
  parameter int unsigned            NUM_BTNS     = 4,
  parameter int unsigned            DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0]  BYTE_BASE    = 8'h41,
  parameter int unsigned            BUSY_TIMEOUT = 15
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_BTNS-1:0]   i_btn_pulse,
  input  logic                  i_tx_busy,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_tx_valid,
  output logic [NUM_BTNS-1:0]   o_pending,
  output logic                  o_drop,
  output logic                  o_timeout
);

  localparam int unsigned PTR_W = $clog2(NUM_BTNS);
  localparam int unsigned TMR_W = $clog2(BUSY_TIMEOUT + 1);
  // Timer value seen on the edge that declares a timeout, so that the pulse
  // appears BUSY_TIMEOUT cycles after the strobe.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

`ifdef BTN_TX_CRLF_EN
  localparam logic [DATA_WIDTH-1:0] CR_BYTE = DATA_WIDTH'(8'h0D);
  localparam logic [DATA_WIDTH-1:0] LF_BYTE = DATA_WIDTH'(8'h0A);

  typedef enum logic [1:0] {
    SEL_BTN,
    SEL_CR,
    SEL_LF
  } byte_sel_t;

  byte_sel_t byte_sel;
`endif

  state_t                state;
  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      grant_q;
  logic [TMR_W-1:0]      timer;
  logic [NUM_BTNS-1:0]   pending;

  logic                  grant_found;
  logic [PTR_W-1:0]      grant_idx;
  logic [DATA_WIDTH-1:0] btn_byte;
  logic                  issue_btn;
  logic [NUM_BTNS-1:0]   clr_mask;

  assign o_pending = pending;

  // Round-robin search: first pending channel after rr_ptr, wrapping around.
  always_comb begin
    logic [PTR_W-1:0] cand;
    cand        = '0;
    grant_found = 1'b0;
    grant_idx   = rr_ptr;
    for (int unsigned i = 1; i <= NUM_BTNS; i++) begin
      cand = PTR_W'((32'(rr_ptr) + i) % NUM_BTNS);
      if (!grant_found && pending[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Byte for the candidate grant; the sum wraps at DATA_WIDTH bits.
  always_comb begin
    btn_byte = BYTE_BASE + DATA_WIDTH'(grant_idx);
  end

  // Pending bit of the granted channel is consumed when its own byte issues
  // (not when a trailing CR/LF issues).
  always_comb begin
`ifdef BTN_TX_CRLF_EN
    issue_btn = (byte_sel == SEL_BTN);
`else
    issue_btn = 1'b1;
`endif
    clr_mask = '0;
    if (state == ISSUE && issue_btn) begin
      clr_mask[grant_q] = 1'b1;
    end
  end

  // Request latching, arbitration FSM and all registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      rr_ptr     <= PTR_W'(NUM_BTNS - 1);
      grant_q    <= '0;
      timer      <= '0;
      pending    <= '0;
      o_tx_data  <= '0;
      o_tx_valid <= 1'b0;
      o_drop     <= 1'b0;
      o_timeout  <= 1'b0;
`ifdef BTN_TX_CRLF_EN
      byte_sel   <= SEL_BTN;
`endif
    end else begin
      o_tx_valid <= 1'b0;
      o_timeout  <= 1'b0;
      // A press landing on the very cycle its bit is consumed is a fresh
      // request, so the clear is applied before the new pulse is OR-ed in.
      pending    <= (pending & ~clr_mask) | i_btn_pulse;
      o_drop     <= |(i_btn_pulse & pending & ~clr_mask);

      case (state)
        IDLE: begin
          if (grant_found && !i_tx_busy) begin
            grant_q   <= grant_idx;
            rr_ptr    <= grant_idx;
            o_tx_data <= btn_byte;
`ifdef BTN_TX_CRLF_EN
            byte_sel  <= SEL_BTN;
`endif
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          o_tx_valid <= 1'b1;
          timer      <= '0;
          state      <= WAIT_BUSY;
        end

        WAIT_BUSY: begin
          if (i_tx_busy) begin
            timer <= '0;
            state <= WAIT_DONE;
          end else if (timer == TMR_LAST) begin
            o_timeout <= 1'b1;
            timer     <= '0;
`ifdef BTN_TX_CRLF_EN
            byte_sel  <= SEL_BTN;
`endif
            state     <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        WAIT_DONE: begin
          if (!i_tx_busy) begin
`ifdef BTN_TX_CRLF_EN
            case (byte_sel)
              SEL_BTN: begin
                o_tx_data <= CR_BYTE;
                byte_sel  <= SEL_CR;
                state     <= ISSUE;
              end
              SEL_CR: begin
                o_tx_data <= LF_BYTE;
                byte_sel  <= SEL_LF;
                state     <= ISSUE;
              end
              default: begin
                byte_sel <= SEL_BTN;
                state    <= IDLE;
              end
            endcase
`else
            state <= IDLE;
`endif
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_tx_arbiter.sv
// Self-checking bench for button_tx_arbiter: table of press patterns with
// hand-computed byte streams, plus directed sequences for latency, drops,
// timeouts and reset in the middle of a transfer.
module tb_button_tx_arbiter;

`ifdef BTN_TX_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b1;
  logic [3:0] i_btn_pulse = '0;
  logic       i_tx_busy;
  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic [3:0] o_pending;
  logic       o_drop;
  logic       o_timeout;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Simple UART model: busy for tx_len cycles after it samples the strobe;
  // tx_len == 0 means it never goes busy.
  int   tx_len = 10;
  int   busy_cnt = 0;
  logic hold_busy = 1'b0;

  logic [7:0] strobes[$];
  int         strobe_cycs[$];
  int         timeout_cycs[$];
  int         drops = 0;
  int         timeouts = 0;
  logic       prev_valid = 1'b0;

  typedef struct {
    logic [3:0] pulses;
    int         n;
    logic [7:0] exp[4];
  } vec_t;

  vec_t vecs[7];

  button_tx_arbiter #(
    .NUM_BTNS(4),
    .DATA_WIDTH(8),
    .BYTE_BASE(8'h41),
    .BUSY_TIMEOUT(15)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_btn_pulse(i_btn_pulse),
    .i_tx_busy(i_tx_busy),
    .o_tx_data(o_tx_data),
    .o_tx_valid(o_tx_valid),
    .o_pending(o_pending),
    .o_drop(o_drop),
    .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc++;

  always @(posedge i_clk) begin
    if (o_tx_valid && tx_len != 0) busy_cnt <= tx_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  assign i_tx_busy = (busy_cnt != 0) || hold_busy;

  // Monitor: log strobes, drops and timeouts; every strobe must be a single
  // cycle and must not overlap a busy transmitter.
  always @(negedge i_clk) begin
    if (o_tx_valid) begin
      strobes.push_back(o_tx_data);
      strobe_cycs.push_back(cyc);
      checks++;
      if (i_tx_busy || prev_valid) begin
        failures++;
        $display("FAIL strobe_protocol: busy=%0b prev_valid=%0b, required busy=0 prev_valid=0",
                 i_tx_busy, prev_valid);
      end
    end
    prev_valid = o_tx_valid;
    if (o_drop) drops++;
    if (o_timeout) begin
      timeouts++;
      timeout_cycs.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic pulse(input logic [3:0] m);
    i_btn_pulse = m;
    @(negedge i_clk);
    i_btn_pulse = '0;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    tick(2);
    i_rst_n = 1'b1;
    tick(1);
  endtask

  task automatic clear_logs();
    strobes.delete();
    strobe_cycs.delete();
    timeout_cycs.delete();
  endtask

  // Wait (bounded) for 25 consecutive cycles with no strobe, no busy and
  // nothing pending.
  task automatic wait_quiet(input string name);
    int quiet = 0;
    int n = 0;
    while (quiet < 25 && n < 800) begin
      @(negedge i_clk);
      n++;
      if (!o_tx_valid && !i_tx_busy && o_pending == 4'b0000) quiet++;
      else quiet = 0;
    end
    check({name, "_settle"}, 32'(quiet >= 25), 32'd1);
  endtask

  task automatic compare_stream(input string name, input logic [7:0] btn_bytes[$], input bit crlf);
    logic [7:0] exp[$];
    foreach (btn_bytes[i]) begin
      exp.push_back(btn_bytes[i]);
      if (crlf) begin
        exp.push_back(8'h0D);
        exp.push_back(8'h0A);
      end
    end
    check({name, "_count"}, strobes.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < strobes.size())
        check($sformatf("%s_byte%0d", name, i), strobes[i], exp[i]);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int d0;
    int t0;
    int n;
    logic [7:0] bq[$];

    vecs[0] = '{4'b0001, 1, '{8'h41, 8'h00, 8'h00, 8'h00}};
    vecs[1] = '{4'b1111, 4, '{8'h42, 8'h43, 8'h44, 8'h41}};
    vecs[2] = '{4'b0100, 1, '{8'h43, 8'h00, 8'h00, 8'h00}};
    vecs[3] = '{4'b1001, 2, '{8'h44, 8'h41, 8'h00, 8'h00}};
    vecs[4] = '{4'b0110, 2, '{8'h42, 8'h43, 8'h00, 8'h00}};
    vecs[5] = '{4'b0011, 2, '{8'h41, 8'h42, 8'h00, 8'h00}};
    vecs[6] = '{4'b1010, 2, '{8'h44, 8'h42, 8'h00, 8'h00}};

    // Reset state.
    #3 i_rst_n = 1'b0;
    tick(2);
    check("rst_tx_data", o_tx_data, 8'h00);
    check("rst_tx_valid", o_tx_valid, 1'b0);
    check("rst_pending", o_pending, 4'b0000);
    check("rst_drop", o_drop, 1'b0);
    check("rst_timeout", o_timeout, 1'b0);
    i_rst_n = 1'b1;
    tick(3);
    check("post_rst_idle", {o_tx_valid, o_pending}, 5'b0);

    // Single press of btn0: strobe two edges after the sampling edge.
    clear_logs();
    c0 = cyc;
    pulse(4'b0001);
    wait_quiet("lat");
    compare_stream("lat", '{8'h41}, CRLF);
    check("lat_edge", (strobe_cycs.size() > 0) ? strobe_cycs[0] - c0 : -1, 3);
    check("lat_pending", o_pending, 4'b0000);

    // All four from reset: strict order 41..44.
    do_reset();
    clear_logs();
    pulse(4'b1111);
    wait_quiet("all4");
    compare_stream("all4", '{8'h41, 8'h42, 8'h43, 8'h44}, CRLF);

    // Table-driven round-robin vectors (rr pointer carries over).
    for (int v = 0; v < 7; v++) begin
      clear_logs();
      d0 = drops;
      pulse(vecs[v].pulses);
      wait_quiet($sformatf("vec%0d", v));
      bq.delete();
      for (int i = 0; i < vecs[v].n; i++) bq.push_back(vecs[v].exp[i]);
      compare_stream($sformatf("vec%0d", v), bq, CRLF);
      check($sformatf("vec%0d_drops", v), drops - d0, 0);
    end

    // Double press of btn2 while the transmitter holds busy.
    clear_logs();
    d0 = drops;
    hold_busy = 1'b1;
    tick(1);
    pulse(4'b0100);
    tick(2);
    pulse(4'b0100);
    tick(2);
    check("drop_count", drops - d0, 1);
    check("drop_pending", o_pending, 4'b0100);
    check("drop_no_grant", strobes.size(), 0);
    hold_busy = 1'b0;
    wait_quiet("drop");
    compare_stream("drop", '{8'h43}, CRLF);

    // Second press one edge after the first: still pending, so dropped.
    clear_logs();
    d0 = drops;
    pulse(4'b0001);
    pulse(4'b0001);
    wait_quiet("dropk1");
    check("dropk1_drops", drops - d0, 1);
    compare_stream("dropk1", '{8'h41}, CRLF);

    // Second press on the edge that consumes the bit: a new request.
    clear_logs();
    d0 = drops;
    pulse(4'b0001);
    tick(1);
    pulse(4'b0001);
    wait_quiet("reissue");
    check("reissue_drops", drops - d0, 0);
    compare_stream("reissue", '{8'h41, 8'h41}, CRLF);

    // Transmitter never goes busy: each grant times out after 15 cycles.
    do_reset();
    tx_len = 0;
    clear_logs();
    t0 = timeouts;
    pulse(4'b1010);
    wait_quiet("tmo");
    compare_stream("tmo", '{8'h42, 8'h44}, 1'b0);
    check("tmo_count", timeouts - t0, 2);
    check("tmo_delay0", (timeout_cycs.size() > 0 && strobe_cycs.size() > 0)
                          ? timeout_cycs[0] - strobe_cycs[0] : -1, 15);
    check("tmo_delay1", (timeout_cycs.size() > 1 && strobe_cycs.size() > 1)
                          ? timeout_cycs[1] - strobe_cycs[1] : -1, 15);
    tx_len = 10;

    // Reset asserted in WAIT_DONE with btn1/btn3 pending.
    tx_len = 30;
    clear_logs();
    pulse(4'b0001);
    tick(6);
    pulse(4'b1010);
    n = 0;
    while (!(o_pending == 4'b1010 && i_tx_busy) && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    check("rstmid_setup", {o_tx_data, o_pending, i_tx_busy}, {8'h41, 4'b1010, 1'b1});
    i_rst_n = 1'b0;
    #1;
    check("rstmid_tx_data", o_tx_data, 8'h00);
    check("rstmid_outs", {o_tx_valid, o_pending, o_drop, o_timeout}, 7'b0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    clear_logs();
    tick(40);
    check("rstmid_no_strobe", strobes.size(), 0);
    tx_len = 10;
    pulse(4'b0100);
    wait_quiet("rstmid_new");
    compare_stream("rstmid_new", '{8'h43}, CRLF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
